// File: rtl/req_encoder32.sv
// 32-input request encoder: accumulates request pulses into a pending set and
// grants them one at a time through a single-entry valid/ready output stage.
module req_encoder32 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] req_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  out_index,
    output logic [31:0] out_onehot,
    output logic [31:0] pending
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      r_state;
    logic [31:0] r_pending;
    logic [4:0]  r_ptr;
    logic [4:0]  r_index;
    logic [31:0] r_onehot;

    logic [31:0] w_rot;
    logic [4:0]  w_off;
    logic [4:0]  w_sel;
    logic        w_load;
    logic [31:0] w_load_mask;

    // Rotate pending so the pointer position lands at bit 0; the lowest set bit
    // of the rotated vector is then the first request at or above the pointer.
    assign w_rot = (r_pending >> r_ptr) | (r_pending << (6'd32 - {1'b0, r_ptr}));

    always_comb begin
        w_off = '0;
        for (int i = 31; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 5'(i);
            end
        end
    end

    assign w_sel  = w_off + r_ptr;
    assign w_load = ((r_state == EMPTY) || out_ready) && (r_pending != '0);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            assign w_load_mask[gi] = w_load && (w_sel == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= EMPTY;
            r_pending <= '0;
            r_ptr     <= '0;
            r_index   <= '0;
            r_onehot  <= '0;
        end else begin
            // A request arriving on the edge its index is loaded stays pending.
            r_pending <= (r_pending & ~w_load_mask) | req_in;
            if (w_load) begin
                r_state  <= FULL;
                r_index  <= w_sel;
                r_onehot <= w_load_mask;
                if (ROUND_ROBIN != 0) begin
                    r_ptr <= w_sel + 5'd1;
                end
            end else if ((r_state == FULL) && out_ready) begin
                r_state  <= EMPTY;
                r_index  <= '0;
                r_onehot <= '0;
            end
        end
    end

    assign out_valid  = (r_state == FULL);
    assign out_index  = r_index;
    assign out_onehot = r_onehot;
    assign pending    = r_pending;

endmodule
